// File: rtl/enemy_bullet_pool.sv
// Fixed pool of enemy bullets: per-frame move, free, player hit test and pixel flag.
// Define ENEMY_BULLET_AIM_EN to steer each bullet horizontally toward the player.
module enemy_bullet_pool #(
  parameter int         NUM_SLOTS     = 3,
  parameter logic [9:0] Y_STEP        = 10'd2,
  parameter logic [9:0] X_STEP        = 10'd1,
  parameter logic [9:0] Y_MAX         = 10'd479,
  parameter logic [9:0] BULLET_SIZE   = 10'd6,
  parameter logic [9:0] PLAYER_W      = 10'd32,
  parameter logic [9:0] PLAYER_H      = 10'd32,
  parameter logic [7:0] FIRE_INTERVAL = 8'd45
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    frame_clk,
  input  logic [9:0]              DrawX,
  input  logic [9:0]              DrawY,
  input  logic                    launch,
  input  logic [9:0]              start_x,
  input  logic [9:0]              start_y,
  input  logic [9:0]              char_pos,
  input  logic [9:0]              char_y,
  output logic                    is_enemy_bullet,
  output logic [10*NUM_SLOTS-1:0] bullet_x,
  output logic [10*NUM_SLOTS-1:0] bullet_y,
  output logic [NUM_SLOTS-1:0]    active,
  output logic                    player_hit,
  output logic [7:0]              hit_count
);

`ifdef ENEMY_BULLET_AIM_EN
  localparam bit AIM_EN = 1'b1;
`else
  localparam bit AIM_EN = 1'b0;
`endif

  localparam logic [9:0] X_LIM = 10'd639 - BULLET_SIZE;

  logic                 fclk_q, fclk_d;
  logic                 tick_q, tick_d;
  logic [9:0]           x_q   [NUM_SLOTS];
  logic [9:0]           x_d   [NUM_SLOTS];
  logic [9:0]           y_q   [NUM_SLOTS];
  logic [9:0]           y_d   [NUM_SLOTS];
  logic [9:0]           dx_q  [NUM_SLOTS];
  logic [9:0]           dx_d  [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] act_q, act_d;
  logic [7:0]           cool_q, cool_d;
  logic                 hit_q, hit_d;
  logic [7:0]           cnt_q, cnt_d;

  logic [9:0]           xm    [NUM_SLOTS];
  logic [9:0]           ym    [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] ov;
  logic [NUM_SLOTS-1:0] spawn_oh;
  logic                 free_any;
  logic [9:0]           spawn_dx;
  logic                 any_hit;

  // Moved position and overlap, in 11 bits so box edges never wrap
  always_comb begin
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (dx_q[i][9] && x_q[i] == 10'd0)
        xm[i] = 10'd0;
      else if (!dx_q[i][9] && dx_q[i] != 10'd0 && x_q[i] >= X_LIM)
        xm[i] = X_LIM;
      else
        xm[i] = x_q[i] + dx_q[i];
      ym[i] = y_q[i] + Y_STEP;
      ov[i] = ({1'b0, xm[i]} < {1'b0, char_pos} + {1'b0, PLAYER_W})
           && ({1'b0, char_pos} < {1'b0, xm[i]} + {1'b0, BULLET_SIZE})
           && ({1'b0, ym[i]} < {1'b0, char_y} + {1'b0, PLAYER_H})
           && ({1'b0, char_y} < {1'b0, ym[i]} + {1'b0, BULLET_SIZE});
    end
  end

  always_comb begin
    spawn_oh = '0;
    free_any = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (!act_q[i] && !free_any) begin
        spawn_oh[i] = 1'b1;
        free_any    = 1'b1;
      end
    end
    spawn_dx = 10'd0;
    if (AIM_EN) begin
      if (start_x < char_pos)
        spawn_dx = X_STEP;
      else if (start_x > char_pos)
        spawn_dx = 10'd0 - X_STEP;
    end
  end

  always_comb begin
    fclk_d  = frame_clk;
    tick_d  = frame_clk & ~fclk_q;
    x_d     = x_q;
    y_d     = y_q;
    dx_d    = dx_q;
    act_d   = act_q;
    cool_d  = cool_q;
    hit_d   = 1'b0;
    cnt_d   = cnt_q;
    any_hit = 1'b0;
    if (tick_q) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (act_q[i]) begin
          x_d[i] = xm[i];
          y_d[i] = ym[i];
          if (ym[i] >= Y_MAX) begin
            act_d[i] = 1'b0;
          end else if (ov[i]) begin
            act_d[i] = 1'b0;
            any_hit  = 1'b1;
          end
        end
      end
      hit_d = any_hit;
      if (any_hit && cnt_q != 8'hFF)
        cnt_d = cnt_q + 8'd1;
      if (cool_q != 8'd0)
        cool_d = cool_q - 8'd1;
      // Spawn slot is chosen from pre-tick occupancy only
      if (launch && cool_q == 8'd0 && free_any) begin
        cool_d = FIRE_INTERVAL;
        for (int i = 0; i < NUM_SLOTS; i++) begin
          if (spawn_oh[i]) begin
            x_d[i]   = start_x;
            y_d[i]   = start_y;
            dx_d[i]  = spawn_dx;
            act_d[i] = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      fclk_q <= 1'b0;
      tick_q <= 1'b0;
      act_q  <= '0;
      cool_q <= 8'd0;
      hit_q  <= 1'b0;
      cnt_q  <= 8'd0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        x_q[i]  <= 10'd0;
        y_q[i]  <= 10'd0;
        dx_q[i] <= 10'd0;
      end
    end else begin
      fclk_q <= fclk_d;
      tick_q <= tick_d;
      act_q  <= act_d;
      cool_q <= cool_d;
      hit_q  <= hit_d;
      cnt_q  <= cnt_d;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        x_q[i]  <= x_d[i];
        y_q[i]  <= y_d[i];
        dx_q[i] <= dx_d[i];
      end
    end
  end

  logic [9:0] px [NUM_SLOTS];
  logic [9:0] py [NUM_SLOTS];

  always_comb begin
    is_enemy_bullet = 1'b0;
    bullet_x        = '0;
    bullet_y        = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      px[i] = DrawX - x_q[i];
      py[i] = DrawY - y_q[i];
      bullet_x[i*10 +: 10] = x_q[i];
      bullet_y[i*10 +: 10] = y_q[i];
      if (act_q[i] && px[i] < BULLET_SIZE && py[i] < BULLET_SIZE)
        is_enemy_bullet = 1'b1;
    end
  end

  assign active     = act_q;
  assign player_hit = hit_q;
  assign hit_count  = cnt_q;

endmodule

// File: tb/tb_enemy_bullet_pool.sv
// Self-checking bench for enemy_bullet_pool: scoreboard queue plus pixel vector table.
// Expectations follow ENEMY_BULLET_AIM_EN when the bench is built with it.
module tb_enemy_bullet_pool;

`ifdef ENEMY_BULLET_AIM_EN
  localparam int AIM = 1;
`else
  localparam int AIM = 0;
`endif

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        frame_clk = 1'b0;
  logic [9:0]  DrawX = '0;
  logic [9:0]  DrawY = '0;
  logic        launch = 1'b0;
  logic [9:0]  start_x = '0;
  logic [9:0]  start_y = '0;
  logic [9:0]  char_pos = '0;
  logic [9:0]  char_y = '0;
  logic        is_enemy_bullet;
  logic [29:0] bullet_x;
  logic [29:0] bullet_y;
  logic [2:0]  active;
  logic        player_hit;
  logic [7:0]  hit_count;

  enemy_bullet_pool dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk),
    .DrawX(DrawX), .DrawY(DrawY), .launch(launch),
    .start_x(start_x), .start_y(start_y),
    .char_pos(char_pos), .char_y(char_y),
    .is_enemy_bullet(is_enemy_bullet),
    .bullet_x(bullet_x), .bullet_y(bullet_y),
    .active(active), .player_hit(player_hit),
    .hit_count(hit_count)
  );

  always #10 Clk = ~Clk;

  int checks = 0;
  int failures = 0;
  int ph_total = 0;
  int ph_base = 0;

  always @(negedge Clk) if (player_hit) ph_total++;

  typedef struct {
    string nm;
    int    sel;
    int    exp;
  } sb_t;
  sb_t sbq[$];

  typedef struct {
    int ox;
    int oy;
    int exp;
  } pix_t;
  pix_t pv[7];

  function automatic int act(int sel);
    case (sel)
      0: return int'(active);
      1, 2, 3: return int'(bullet_x[(sel-1)*10 +: 10]);
      4, 5, 6: return int'(bullet_y[(sel-4)*10 +: 10]);
      7: return int'(hit_count);
      8: return int'(player_hit);
      9: return int'(is_enemy_bullet);
      10: return ph_total - ph_base;
      default: return -1;
    endcase
  endfunction

  task automatic push(string nm, int sel, int exp);
    sbq.push_back('{nm, sel, exp});
  endtask

  task automatic drain();
    sb_t s;
    int a;
    while (sbq.size() > 0) begin
      s = sbq.pop_front();
      a = act(s.sel);
      checks++;
      if (a != s.exp) begin
        failures++;
        $display("FAIL %s actual=%0d expected=%0d", s.nm, a, s.exp);
      end
    end
  endtask

  task automatic tick();
    @(negedge Clk) frame_clk = 1'b1;
    @(negedge Clk) frame_clk = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
  endtask

  task automatic do_reset();
    @(negedge Clk) Reset = 1'b1;
    @(negedge Clk) Reset = 1'b0;
    launch = 1'b0;
  endtask

  initial begin
    pv[0] = '{2, 3, 1};
    pv[1] = '{6, 3, 0};
    pv[2] = '{0, 0, 1};
    pv[3] = '{5, 5, 1};
    pv[4] = '{-1, 0, 0};
    pv[5] = '{0, 6, 0};
    pv[6] = '{5, -1, 0};

    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    push("rst_active", 0, 0);
    push("rst_hitcnt", 7, 0);
    push("rst_phit", 8, 0);
    push("rst_x0", 1, 0);
    push("rst_y0", 4, 0);
    drain();

    // launch pulsed between ticks is ignored
    start_x = 10'd600; start_y = 10'd20;
    char_pos = 10'd100; char_y = 10'd400;
    @(negedge Clk) launch = 1'b1;
    @(negedge Clk);
    @(negedge Clk) launch = 1'b0;
    push("off_tick_launch", 0, 0);
    tick();
    drain();

    // fill order, cooldown, dropped request, respawn after free
    ph_base = ph_total;
    for (int n = 1; n <= 232; n++) begin
      launch = (n != 2);
      if (n == 1) begin
        push("spawn0_act", 0, 1);
        push("spawn0_x", 1, 600);
        push("spawn0_y", 4, 20);
      end
      if (n == 2) begin
        push("move0_x", 1, AIM ? 599 : 600);
        push("move0_y", 4, 22);
      end
      if (n == 46) push("cooldown_block", 0, 1);
      if (n == 47) begin
        push("spawn1_act", 0, 3);
        push("spawn1_x", 2, 600);
        push("spawn1_y", 5, 20);
      end
      if (n == 93) push("spawn2_act", 0, 7);
      if (n == 139) begin
        push("full_drop", 0, 7);
        push("full_y0", 4, 296);
      end
      if (n == 230) push("pre_free_act", 0, 7);
      if (n == 231) push("free0_act", 0, 6);
      if (n == 232) begin
        push("respawn_act", 0, 7);
        push("respawn_y0", 4, 20);
      end
      tick();
      drain();
    end
    push("fill_no_hit", 10, 0);
    push("fill_hitcnt", 7, 0);
    drain();

    // bottom boundary: 474 -> 476 -> 478 -> 480 freed
    do_reset();
    ph_base = ph_total;
    start_x = 10'd100; start_y = 10'd474;
    char_pos = 10'd100; char_y = 10'd0;
    launch = 1'b1;
    push("edge_spawn", 0, 1);
    tick(); drain();
    launch = 1'b0;
    push("edge_476_act", 0, 1);
    push("edge_476_y", 4, 476);
    tick(); drain();
    push("edge_478_act", 0, 1);
    push("edge_478_y", 4, 478);
    tick(); drain();
    push("edge_480_free", 0, 0);
    push("edge_no_hit", 10, 0);
    tick(); drain();

    // single hit
    do_reset();
    start_x = 10'd100; start_y = 10'd60;
    char_pos = 10'd98; char_y = 10'd64;
    launch = 1'b1;
    push("hit_spawn_noTest", 0, 1);
    tick(); drain();
    launch = 1'b0;
    ph_base = ph_total;
    push("hit_clear", 0, 0);
    push("hit_pulse", 10, 1);
    push("hit_cnt1", 7, 1);
    tick(); drain();

    // saturate hit_count
    launch = 1'b1;
    for (int k = 0; k < 13000 && hit_count != 8'hFF; k++) tick();
    push("sat_reach", 7, 255);
    drain();
    ph_base = ph_total;
    for (int k = 0; k < 60 && ph_total == ph_base; k++) tick();
    push("sat_hold", 7, 255);
    push("sat_pulse", 10, 1);
    drain();

    // reset with a bullet in flight
    char_y = 10'd400;
    for (int k = 0; k < 60 && active == 3'b000; k++) tick();
    push("inflight_act", 0, 1);
    drain();
    @(negedge Clk) Reset = 1'b1;
    @(negedge Clk);
    push("midrst_act", 0, 0);
    push("midrst_cnt", 7, 0);
    push("midrst_x0", 1, 0);
    drain();
    Reset = 1'b0;
    launch = 1'b0;

    // straight fall and pixel flag table
    start_x = 10'd300; start_y = 10'd100;
    char_pos = 10'd50; char_y = 10'd400;
    launch = 1'b1;
    tick();
    launch = 1'b0;
    repeat (10) tick();
    push("fall_x", 1, AIM ? 290 : 300);
    push("fall_y", 4, 120);
    drain();
    for (int i = 0; i < 7; i++) begin
      DrawX = 10'((AIM ? 290 : 300) + pv[i].ox);
      DrawY = 10'(120 + pv[i].oy);
      push($sformatf("pix%0d", i), 9, pv[i].exp);
      #1;
      drain();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
